// File: rtl/seq_pkg.sv
// Shared types and constants for the program run-control sequencer:
// FSM state encoding, resident program count and program base addresses.
package seq_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int CYC_W_DEF   = 16;
  localparam int NUM_PROG    = 3;
  localparam int MAX_CYC_DEF = 2**16 - 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } seq_state_t;

  // Program map: P1, P2, P3 entry points in instruction memory
  localparam logic [PC_W_DEF-1:0] PROG_BASE [NUM_PROG] = '{10'h000, 10'h100, 10'h200};

  function automatic logic [PC_W_DEF-1:0] base_addr(input logic [1:0] idx);
    case (idx)
      2'd1:    base_addr = PROG_BASE[1];
      2'd2:    base_addr = PROG_BASE[2];
      default: base_addr = PROG_BASE[0];
    endcase
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Per-run cycle counter with synchronous clear and saturation; at_limit flags
// the counting cycle that brings the count onto the watchdog limit.
import seq_pkg::*;

module seq_cycle_counter #(
  parameter int CYC_W   = CYC_W_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CYC_W-1:0] LIMIT    = CYC_W'(MAX_CYC);
  localparam logic [CYC_W-1:0] LIMIT_M1 = CYC_W'(MAX_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && (count != LIMIT))
      count <= count + 1'b1;
  end

  // Asserted during the run cycle whose increment lands on LIMIT
  assign at_limit = en && (count >= LIMIT_M1);

endmodule

// File: rtl/program_sequencer.sv
// Run-control FSM: arms a resident program on Start, launches it when Start
// falls, gates core execution until Halt or watchdog, then reports Ack.
import seq_pkg::*;

module program_sequencer #(
  parameter int PC_W    = PC_W_DEF,
  parameter int CYC_W   = CYC_W_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_addr,
  output logic             run_en,
  output logic             ack,
  output logic             timeout,
  output logic [1:0]       prog_idx,
  output logic [CYC_W-1:0] cycle_count
);

  seq_state_t state, next_state;
  logic       at_limit;
  logic       timeout_q;
  logic [1:0] idx_q;
  logic [1:0] idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Start beats Halt and the watchdog so an abort always restarts the program
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = ARM;
      ARM:        if (!start) next_state = RUN;
      RUN: begin
        if (start)
          next_state = ARM;
        else if (halt || at_limit)
          next_state = DONE;
      end
      default:    next_state = IDLE;
    endcase
  end

  assign idx_next = (idx_q == 2'(NUM_PROG - 1)) ? 2'd0 : idx_q + 2'd1;

  // A Halt landing on the watchdog cycle still counts as a clean finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else if (next_state == ARM) begin
      timeout_q <= 1'b0;
    end else if ((state == RUN) && (next_state == DONE)) begin
      timeout_q <= !halt;
      idx_q     <= idx_next;
    end
  end

  seq_cycle_counter #(
    .CYC_W   (CYC_W),
    .MAX_CYC (MAX_CYC)
  ) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (next_state == ARM),
    .en       (state == RUN),
    .count    (cycle_count),
    .at_limit (at_limit)
  );

  assign pc_load      = (state == ARM);
  assign run_en       = (state == RUN);
  assign ack          = (state == DONE);
  assign timeout      = timeout_q;
  assign prog_idx     = idx_q;
  assign pc_load_addr = PC_W'(base_addr(idx_q));

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: per-run transaction model,
// a table of cycle vectors for handshake corner cases, and randomized runs.
module tb_program_sequencer;

  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        pc_load;
  logic [9:0]  pc_load_addr;
  logic        run_en;
  logic        ack;
  logic        timeout;
  logic [1:0]  prog_idx;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  int expIdx   = 0;
  logic [9:0] baseTab [3] = '{10'h000, 10'h100, 10'h200};

  typedef struct {
    logic start;
    logic halt;
    logic pcl;
    logic run;
    logic ack;
    int   cnt;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  program_sequencer #(
    .PC_W    (10),
    .CYC_W   (16),
    .MAX_CYC (MAXC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt         (halt),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .run_en       (run_en),
    .ack          (ack),
    .timeout      (timeout),
    .prog_idx     (prog_idx),
    .cycle_count  (cycle_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h);
    start = s;
    halt  = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkArm(input string tag);
    checkOutput({tag, " pc_load"}, 32'(pc_load), 1);
    checkOutput({tag, " run_en"}, 32'(run_en), 0);
    checkOutput({tag, " ack"}, 32'(ack), 0);
    checkOutput({tag, " timeout"}, 32'(timeout), 0);
    checkOutput({tag, " count"}, 32'(cycle_count), 0);
    checkOutput({tag, " prog_idx"}, 32'(prog_idx), 32'(expIdx));
    checkOutput({tag, " addr"}, 32'(pc_load_addr), 32'(baseTab[expIdx]));
  endtask

  // Called in the first RUN cycle; haltAt/abortAt of 0 mean never
  task automatic runPhase(input int haltAt, input int abortAt, output bit aborted);
    int limit;
    limit   = (haltAt > 0 && haltAt < MAXC) ? haltAt : MAXC;
    aborted = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      checkOutput("run run_en", 32'(run_en), 1);
      checkOutput("run pc_load", 32'(pc_load), 0);
      checkOutput("run count", 32'(cycle_count), 32'(c - 1));
      applyStimulus(c == abortAt, c == haltAt);
      tick();
      applyStimulus(1'b0, 1'b0);
      if (c == abortAt) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic doRun(input int armLen, input int haltAt, input int abortAt);
    bit   aborted;
    int   expCycles;
    logic expTo;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < armLen; i++) begin
      tick();
      checkArm("arm");
    end
    applyStimulus(1'b0, 1'b0);
    tick();
    runPhase(haltAt, abortAt, aborted);
    if (aborted) begin
      checkArm("abort");
      tick();
      runPhase(haltAt, 0, aborted);
    end
    expTo     = !(haltAt > 0 && haltAt <= MAXC);
    expCycles = expTo ? MAXC : haltAt;
    expIdx    = (expIdx + 1) % 3;
    checkOutput("done run_en", 32'(run_en), 0);
    checkOutput("done pc_load", 32'(pc_load), 0);
    checkOutput("done ack", 32'(ack), 1);
    checkOutput("done timeout", 32'(timeout), 32'(expTo));
    checkOutput("done count", 32'(cycle_count), 32'(expCycles));
    checkOutput("done prog_idx", 32'(prog_idx), 32'(expIdx));
    checkOutput("done addr", 32'(pc_load_addr), 32'(baseTab[expIdx]));
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("dwell ack", 32'(ack), 1);
    checkOutput("dwell count", 32'(cycle_count), 32'(expCycles));
    checkOutput("dwell prog_idx", 32'(prog_idx), 32'(expIdx));
  endtask

  initial begin
    int r;
    int lim;
    int ab;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pc_load", 32'(pc_load), 0);
    checkOutput("reset run_en", 32'(run_en), 0);
    checkOutput("reset ack", 32'(ack), 0);
    checkOutput("reset timeout", 32'(timeout), 0);
    checkOutput("reset prog_idx", 32'(prog_idx), 0);
    checkOutput("reset count", 32'(cycle_count), 0);
    checkOutput("reset addr", 32'(pc_load_addr), 32'(baseTab[0]));
    rst_n = 1'b1;
    tick();

    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("idle halt run_en", 32'(run_en), 0);
    checkOutput("idle halt pc_load", 32'(pc_load), 0);
    checkOutput("idle halt ack", 32'(ack), 0);
    checkOutput("idle halt prog_idx", 32'(prog_idx), 0);

    doRun(1, 5, 0);
    doRun(1, 7, 0);
    doRun(1, 9, 0);
    checkOutput("wrap prog_idx", 32'(prog_idx), 0);
    doRun(1, 15, 0);
    doRun(1, 15, 10);

    // Four-cycle Start, RUN, then Start+Halt together, then a first-cycle Halt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].start, tbl[i].halt);
      tick();
      checkOutput($sformatf("vec%0d pc_load", i), 32'(pc_load), 32'(tbl[i].pcl));
      checkOutput($sformatf("vec%0d run_en", i), 32'(run_en), 32'(tbl[i].run));
      checkOutput($sformatf("vec%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      checkOutput($sformatf("vec%0d count", i), 32'(cycle_count), 32'(tbl[i].cnt));
    end
    applyStimulus(1'b0, 1'b0);
    expIdx = (expIdx + 1) % 3;
    checkOutput("vec prog_idx", 32'(prog_idx), 32'(expIdx));
    checkOutput("vec timeout", 32'(timeout), 0);

    doRun(2, 0, 0);
    doRun(1, 30, 0);

    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(1, 29);
      if (r == MAXC) r = MAXC - 1;
      lim = (r < MAXC) ? r : MAXC;
      ab  = 0;
      if ($urandom_range(0, 2) == 0 && lim >= 2) ab = $urandom_range(1, lim - 1);
      doRun($urandom_range(1, 3), r, ab);
    end

    if (expIdx == 0) doRun(1, 3, 0);
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("pre-reset run_en", 32'(run_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    expIdx = 0;
    checkOutput("async reset run_en", 32'(run_en), 0);
    checkOutput("async reset pc_load", 32'(pc_load), 0);
    checkOutput("async reset ack", 32'(ack), 0);
    checkOutput("async reset timeout", 32'(timeout), 0);
    checkOutput("async reset prog_idx", 32'(prog_idx), 0);
    checkOutput("async reset count", 32'(cycle_count), 0);
    checkOutput("async reset addr", 32'(pc_load_addr), 32'(baseTab[0]));
    rst_n = 1'b1;
    tick();
    checkOutput("post reset run_en", 32'(run_en), 0);
    checkOutput("post reset pc_load", 32'(pc_load), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
